// File: rtl/seq_booth_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_pkg
// Description : Shared types and sizing helpers for the sequential Booth
//               multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One Booth step per extended operand bit (WIDTH plus the extension bit).
    function automatic int iter_count(input int width);
        return width + 1;
    endfunction

    // The counter must be able to hold iter_count(width) - 1 with margin.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_booth_mult_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_booth_mult_if
// Description : Operand/handshake/result bundle of the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_booth_mult_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       in1;
    logic [WIDTH-1:0]       in2;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     prod;

    modport master (
        output start, signed_mode, in1, in2,
        input  busy, done, prod
    );

    modport slave (
        input  start, signed_mode, in1, in2,
        output busy, done, prod
    );
endinterface
`default_nettype wire

// File: rtl/seq_booth_mult_booth_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_step
// Description : One combinational radix-2 Booth step (add/sub then arithmetic
//               right shift of {A, Q, q-1}).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step #(
    parameter int N = 33
) (
    input  wire logic [N:0]   i_a,
    input  wire logic [N-1:0] i_q,
    input  wire logic         i_q_m1,
    input  wire logic [N-1:0] i_m,
    output logic      [N:0]   o_a_next,
    output logic      [N-1:0] o_q_next,
    output logic              o_q_m1_next
);
    logic [N:0] w_m_ext;
    logic [N:0] w_sum;

    always_comb begin
        w_m_ext = {i_m[N-1], i_m};
        w_sum   = i_a;
        case ({i_q[0], i_q_m1})
            2'b01:   w_sum = i_a + w_m_ext;
            2'b10:   w_sum = i_a - w_m_ext;
            default: w_sum = i_a;
        endcase
        o_a_next    = {w_sum[N], w_sum[N:1]};
        o_q_next    = {w_sum[0], i_q[N-1:1]};
        o_q_m1_next = i_q[0];
    end
endmodule
`default_nettype wire

// File: rtl/seq_booth_mult.sv
`default_nettype none
// ============================================================================
// Module      : seq_booth_mult
// Description : Parametrised radix-2 Booth sequential multiplier with
//               start/busy/done handshake and signed/unsigned mode.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_booth_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    seq_booth_mult_if.slave   bus
);
    localparam int CNT_W  = cnt_width(WIDTH);
    localparam int C_LAST = iter_count(WIDTH) - 1;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_finish;

    logic [WIDTH+1:0]   r_a;
    logic [WIDTH:0]     r_q;
    logic               r_q_m1;
    logic [WIDTH:0]     r_m;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_prod;

    logic [WIDTH+1:0]   w_a_next;
    logic [WIDTH:0]     w_q_next;
    logic               w_q_m1_next;
    logic [WIDTH:0]     w_in1_ext;
    logic [WIDTH:0]     w_in2_ext;

    booth_step #(
        .N (WIDTH + 1)
    ) u_booth_step (
        .i_a         (r_a),
        .i_q         (r_q),
        .i_q_m1      (r_q_m1),
        .i_m         (r_m),
        .o_a_next    (w_a_next),
        .o_q_next    (w_q_next),
        .o_q_m1_next (w_q_m1_next)
    );

    // One extra operand bit lets unsigned values ride the signed Booth datapath.
    assign w_in1_ext = {bus.signed_mode & bus.in1[WIDTH-1], bus.in1};
    assign w_in2_ext = {bus.signed_mode & bus.in2[WIDTH-1], bus.in2};

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = RUN;
                    w_accept     = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == CNT_W'(C_LAST)) begin
                    w_state_next = DONE;
                    w_finish     = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_state_next = RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_q_m1  <= 1'b0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a    <= '0;
                r_q    <= w_in2_ext;
                r_q_m1 <= 1'b0;
                r_m    <= w_in1_ext;
                r_cnt  <= '0;
            end else if (r_state == RUN) begin
                r_a    <= w_a_next;
                r_q    <= w_q_next;
                r_q_m1 <= w_q_m1_next;
                r_cnt  <= r_cnt + 1'b1;
            end
            // Low 2*WIDTH bits of the extended product are exact in both modes.
            if (w_finish) begin
                r_prod <= {w_a_next[WIDTH-2:0], w_q_next};
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.prod = r_prod;
endmodule
`default_nettype wire
